// File: rtl/eth_frame_encap.sv
// eth_frame_encap: GMII transmit-side Ethernet frame encapsulator.
// It builds each frame from the queued packet in this order: preamble,
// SFD, destination and source MAC, length field, payload from the FIFO,
// zero padding and the CRC-32 FCS. A fixed inter-frame gap follows.
// The data and valid outputs are registered. The byte chosen in a state
// cycle therefore appears on the GMII pins one cycle later.
module eth_frame_encap #(
    parameter logic [47:0] DEST_MAC = 48'h40ac14dfbb66,
    parameter logic [47:0] SRC_MAC  = 48'he044e435dba6,
    parameter int          IFG_LEN  = 12
) (
    input  logic        eth_tx_clk,
    input  logic        rst,
    input  logic        eth_tx_en,
    input  logic [1:0]  bf_out_buffer_ready,
    input  logic [10:0] pld_len,
    input  logic [7:0]  ff_out_data_in,
    output logic        bf_in_r_en,
    output logic        bf_in_pct_txed,
    output logic [7:0]  gmii_txd,
    output logic        gmii_tx_en
);

    localparam logic [3:0] S_IDLE = 4'd0;
    localparam logic [3:0] S_PRE  = 4'd1;
    localparam logic [3:0] S_SFD  = 4'd2;
    localparam logic [3:0] S_DST  = 4'd3;
    localparam logic [3:0] S_SRC  = 4'd4;
    localparam logic [3:0] S_LEN  = 4'd5;
    localparam logic [3:0] S_PLD  = 4'd6;
    localparam logic [3:0] S_PAD  = 4'd7;
    localparam logic [3:0] S_FCS  = 4'd8;
    localparam logic [3:0] S_IFG  = 4'd9;

    localparam logic [10:0] MAX_LEN  = 11'd1500;
    localparam logic [10:0] MIN_DATA = 11'd46;
    localparam logic [10:0] IFG_LAST = 11'(IFG_LEN - 1);

    // One byte of the reflected CRC-32 (poly 0xEDB88320), data taken LSB first.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc,
                                               input logic [7:0]  data);
        logic [31:0] r;
        r = crc;
        for (int i = 0; i < 8; i++) begin
            if (r[0] ^ data[i]) begin
                r = (r >> 1) ^ 32'hEDB88320;
            end else begin
                r = r >> 1;
            end
        end
        return r;
    endfunction

    // Byte idx of a MAC address. The most significant byte goes out first.
    function automatic logic [7:0] mac_byte(input logic [47:0] mac,
                                            input logic [10:0] idx);
        logic [7:0] b;
        case (idx)
            11'd0:   b = mac[47:40];
            11'd1:   b = mac[39:32];
            11'd2:   b = mac[31:24];
            11'd3:   b = mac[23:16];
            11'd4:   b = mac[15:8];
            11'd5:   b = mac[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    logic [3:0]  state_q, state_d;
    logic [10:0] cnt_q, cnt_d;
    logic [10:0] len_q, len_d;
    logic [31:0] crc_q, crc_d;
    logic [7:0]  txd_q;
    logic        txen_q;
    logic        ren_q, ren_d;
    logic        txed_q, txed_d;
    logic [7:0]  byte_s;
    logic        valid_s;
    logic        crc_upd_s;
    logic [31:0] fcs_s;

    // Frame sequencing. cnt counts bytes within the current state.
    // On entry to PAD, cnt continues from L so that PAD always ends at data byte 45.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        case (state_q)
            S_IDLE: begin
                cnt_d = 11'd0;
                if (eth_tx_en && (bf_out_buffer_ready != 2'd0)) begin
                    state_d = S_PRE;
                    len_d   = (pld_len > MAX_LEN) ? MAX_LEN : pld_len;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_PRE: begin
                if (cnt_q == 11'd6) begin
                    state_d = S_SFD;
                    cnt_d   = 11'd0;
                end else begin
                    cnt_d = cnt_q + 11'd1;
                end
            end
            S_SFD: begin
                state_d = S_DST;
                cnt_d   = 11'd0;
            end
            S_DST: begin
                if (cnt_q == 11'd5) begin
                    state_d = S_SRC;
                    cnt_d   = 11'd0;
                end else begin
                    cnt_d = cnt_q + 11'd1;
                end
            end
            S_SRC: begin
                if (cnt_q == 11'd5) begin
                    state_d = S_LEN;
                    cnt_d   = 11'd0;
                end else begin
                    cnt_d = cnt_q + 11'd1;
                end
            end
            S_LEN: begin
                if (cnt_q == 11'd1) begin
                    if (len_q == 11'd0) begin
                        state_d = S_PAD;
                    end else begin
                        state_d = S_PLD;
                    end
                    cnt_d = 11'd0;
                end else begin
                    cnt_d = cnt_q + 11'd1;
                end
            end
            S_PLD: begin
                if (cnt_q == (len_q - 11'd1)) begin
                    if (len_q < MIN_DATA) begin
                        state_d = S_PAD;
                        cnt_d   = len_q;
                    end else begin
                        state_d = S_FCS;
                        cnt_d   = 11'd0;
                    end
                end else begin
                    cnt_d = cnt_q + 11'd1;
                end
            end
            S_PAD: begin
                if (cnt_q == (MIN_DATA - 11'd1)) begin
                    state_d = S_FCS;
                    cnt_d   = 11'd0;
                end else begin
                    cnt_d = cnt_q + 11'd1;
                end
            end
            S_FCS: begin
                if (cnt_q == 11'd3) begin
                    state_d = S_IFG;
                    cnt_d   = 11'd0;
                end else begin
                    cnt_d = cnt_q + 11'd1;
                end
            end
            S_IFG: begin
                if (cnt_q == IFG_LAST) begin
                    state_d = S_IDLE;
                    cnt_d   = 11'd0;
                end else begin
                    cnt_d = cnt_q + 11'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 11'd0;
            end
        endcase
    end

    // Choose the byte for the current state cycle and decide if it enters the CRC.
    always_comb begin
        byte_s    = 8'h00;
        valid_s   = 1'b0;
        crc_upd_s = 1'b0;
        fcs_s     = ~crc_q;
        case (state_q)
            S_PRE: begin
                byte_s  = 8'h55;
                valid_s = 1'b1;
            end
            S_SFD: begin
                byte_s  = 8'hD5;
                valid_s = 1'b1;
            end
            S_DST: begin
                byte_s    = mac_byte(DEST_MAC, cnt_q);
                valid_s   = 1'b1;
                crc_upd_s = 1'b1;
            end
            S_SRC: begin
                byte_s    = mac_byte(SRC_MAC, cnt_q);
                valid_s   = 1'b1;
                crc_upd_s = 1'b1;
            end
            S_LEN: begin
                if (cnt_q == 11'd0) begin
                    byte_s = {5'b00000, len_q[10:8]};
                end else begin
                    byte_s = len_q[7:0];
                end
                valid_s   = 1'b1;
                crc_upd_s = 1'b1;
            end
            S_PLD: begin
                byte_s    = ff_out_data_in;
                valid_s   = 1'b1;
                crc_upd_s = 1'b1;
            end
            S_PAD: begin
                byte_s    = 8'h00;
                valid_s   = 1'b1;
                crc_upd_s = 1'b1;
            end
            S_FCS: begin
                case (cnt_q[1:0])
                    2'd0:    byte_s = fcs_s[7:0];
                    2'd1:    byte_s = fcs_s[15:8];
                    2'd2:    byte_s = fcs_s[23:16];
                    2'd3:    byte_s = fcs_s[31:24];
                    default: byte_s = 8'h00;
                endcase
                valid_s = 1'b1;
            end
            default: begin
                byte_s    = 8'h00;
                valid_s   = 1'b0;
                crc_upd_s = 1'b0;
            end
        endcase
    end

    // CRC next value: seeded while idle, advanced on every byte it covers.
    always_comb begin
        if (state_q == S_IDLE) begin
            crc_d = 32'hFFFFFFFF;
        end else if (crc_upd_s) begin
            crc_d = crc32_byte(crc_q, byte_s);
        end else begin
            crc_d = crc_q;
        end
    end

    // Registered FIFO strobes, derived from the upcoming state.
    // The read for payload byte i is therefore issued one cycle before PLD cycle i.
    always_comb begin
        if ((state_d == S_LEN) && (cnt_d == 11'd1) && (len_q != 11'd0)) begin
            ren_d = 1'b1;
        end else if ((state_d == S_PLD) && (cnt_d < (len_q - 11'd1))) begin
            ren_d = 1'b1;
        end else begin
            ren_d = 1'b0;
        end
        txed_d = (state_d == S_FCS) && (cnt_d == 11'd3);
    end

    // State, counters, CRC and registered outputs. Reset aborts any frame.
    always_ff @(posedge eth_tx_clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 11'd0;
            len_q   <= 11'd0;
            crc_q   <= 32'd0;
            txd_q   <= 8'h00;
            txen_q  <= 1'b0;
            ren_q   <= 1'b0;
            txed_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            crc_q   <= crc_d;
            txd_q   <= byte_s;
            txen_q  <= valid_s;
            ren_q   <= ren_d;
            txed_q  <= txed_d;
        end
    end

    assign gmii_txd       = txd_q;
    assign gmii_tx_en     = txen_q;
    assign bf_in_r_en     = ren_q;
    assign bf_in_pct_txed = txed_q;

endmodule

// File: tb/tb_eth_frame_encap.sv
// Randomized bench for eth_frame_encap. A queue-based reference model
// builds each expected frame from the framing rules.
module tb_eth_frame_encap;

    localparam logic [47:0] DST_MAC = 48'h40ac14dfbb66;
    localparam logic [47:0] SRC_MAC = 48'he044e435dba6;

    logic        clk = 1'b0;
    logic        rst;
    logic        eth_tx_en;
    logic        flush;
    logic [1:0]  bf_out_buffer_ready;
    logic [10:0] pld_len;
    logic [7:0]  ff_data = 8'h00;
    logic        bf_in_r_en;
    logic        bf_in_pct_txed;
    logic [7:0]  gmii_txd;
    logic        gmii_tx_en;

    int total = 0;
    int bad   = 0;

    logic [7:0] fifo_mem [0:8191];
    int lens  [0:31];
    int bases [0:31];
    int pushed = 0;
    int wr_ptr = 0;
    int txed_cnt = 0;
    int rd_ptr = 0;

    always #5 clk = ~clk;

    eth_frame_encap dut (
        .eth_tx_clk          (clk),
        .rst                 (rst),
        .eth_tx_en           (eth_tx_en),
        .bf_out_buffer_ready (bf_out_buffer_ready),
        .pld_len             (pld_len),
        .ff_out_data_in      (ff_data),
        .bf_in_r_en          (bf_in_r_en),
        .bf_in_pct_txed      (bf_in_pct_txed),
        .gmii_txd            (gmii_txd),
        .gmii_tx_en          (gmii_tx_en)
    );

    assign bf_out_buffer_ready = ((pushed - txed_cnt) >= 3) ? 2'd3 : 2'(pushed - txed_cnt);
    assign pld_len = 11'(lens[txed_cnt]);

    // Upstream FIFO model: registered read port and packet-ready counter.
    always @(posedge clk) begin
        if (flush) begin
            rd_ptr   <= wr_ptr;
            txed_cnt <= pushed;
        end else begin
            if (bf_in_r_en) begin
                ff_data <= fifo_mem[rd_ptr];
                rd_ptr  <= rd_ptr + 1;
            end
            if (bf_in_pct_txed) txed_cnt <= txed_cnt + 1;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++) r = (r[0] ^ b[i]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    // Queue a packet. Mode 0 uses the payload 1,2,3,...; mode 1 uses random bytes.
    task automatic push_pkt(input int plen, input int mode);
        int leff;
        leff = (plen > 1500) ? 1500 : plen;
        bases[pushed] = wr_ptr;
        for (int i = 0; i < leff; i++)
            fifo_mem[wr_ptr + i] = (mode == 0) ? 8'(i + 1) : 8'($urandom_range(0, 255));
        lens[pushed] = plen;
        wr_ptr = wr_ptr + leff;
        pushed = pushed + 1;
    endtask

    // Capture one frame from the GMII pins and compare it with the model.
    task automatic capture_check(input int pkt);
        logic [7:0]  exp_q[$];
        logic [7:0]  got_q[$];
        logic [31:0] c;
        int leff, n, ren_n, pct_n, m;
        leff = (lens[pkt] > 1500) ? 1500 : lens[pkt];
        for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
        exp_q.push_back(8'hD5);
        for (int i = 0; i < 6; i++) exp_q.push_back(8'(DST_MAC >> (8 * (5 - i))));
        for (int i = 0; i < 6; i++) exp_q.push_back(8'(SRC_MAC >> (8 * (5 - i))));
        exp_q.push_back(8'(leff >> 8));
        exp_q.push_back(8'(leff));
        for (int i = 0; i < leff; i++) exp_q.push_back(fifo_mem[bases[pkt] + i]);
        for (int i = leff; i < 46; i++) exp_q.push_back(8'h00);
        c = 32'hFFFFFFFF;
        for (int i = 8; i < exp_q.size(); i++) c = crc_step(c, exp_q[i]);
        c = ~c;
        for (int i = 0; i < 4; i++) exp_q.push_back(8'(c >> (8 * i)));

        n = 0;
        while (!gmii_tx_en && n < 400) begin
            @(negedge clk);
            n++;
        end
        check_val($sformatf("start_p%0d", pkt), 32'(n < 400), 32'd1);
        n = 0; ren_n = 0; pct_n = 0;
        while (gmii_tx_en && n < 2000) begin
            got_q.push_back(gmii_txd);
            if (bf_in_r_en) ren_n++;
            if (bf_in_pct_txed) pct_n++;
            @(negedge clk);
            n++;
        end
        check_val($sformatf("len_p%0d", pkt), 32'(got_q.size()), 32'(26 + ((leff > 46) ? leff : 46)));
        m = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < m; i++)
            check_val($sformatf("byte_p%0d_%0d", pkt, i), 32'(got_q[i]), 32'(exp_q[i]));
        check_val($sformatf("ren_p%0d", pkt), 32'(ren_n), 32'(leff));
        check_val($sformatf("txed_p%0d", pkt), 32'(pct_n), 32'd1);
        check_val($sformatf("idle_txd_p%0d", pkt), 32'(gmii_txd), 32'd0);
        c = 32'hFFFFFFFF;
        for (int i = 8; i < got_q.size(); i++) c = crc_step(c, got_q[i]);
        check_val($sformatf("residue_p%0d", pkt), ~c, 32'h2144DF1C);
    endtask

    initial begin
        int n, gap, txs, rens;
        for (int i = 0; i < 32; i++) begin
            lens[i]  = 0;
            bases[i] = 0;
        end
        rst = 1'b1;
        flush = 1'b1;
        eth_tx_en = 1'b1;
        repeat (3) @(negedge clk);
        check_val("rst_txen", 32'(gmii_tx_en), 32'd0);
        check_val("rst_txd", 32'(gmii_txd), 32'd0);
        check_val("rst_ren", 32'(bf_in_r_en), 32'd0);
        check_val("rst_txed", 32'(bf_in_pct_txed), 32'd0);
        rst = 1'b0;
        flush = 1'b0;

        // Nothing queued: the block must stay silent.
        txs = 0; rens = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (gmii_tx_en) txs++;
            if (bf_in_r_en) rens++;
        end
        check_val("noready_txen", 32'(txs), 32'd0);
        check_val("noready_ren", 32'(rens), 32'd0);

        // A packet is queued but transmit is disabled: no frame may start.
        eth_tx_en = 1'b0;
        push_pkt(10, 0);
        txs = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (gmii_tx_en) txs++;
        end
        check_val("txdis_txen", 32'(txs), 32'd0);
        eth_tx_en = 1'b1;
        capture_check(0);

        push_pkt(46, 0);
        capture_check(1);
        push_pkt(0, 0);
        capture_check(2);

        // Two packets queued back to back.
        push_pkt($urandom_range(1, 60), 1);
        push_pkt($urandom_range(1, 120), 1);
        capture_check(3);
        gap = 1;
        @(negedge clk);
        while (!gmii_tx_en && gap < 100) begin
            gap++;
            @(negedge clk);
        end
        check_val("b2b_gap", 32'(gap), 32'd13);
        capture_check(4);

        for (int k = 5; k < 8; k++) begin
            push_pkt($urandom_range(0, 200), 1);
            capture_check(k);
        end

        // An oversize length is clamped to 1500 bytes.
        push_pkt(1600, 1);
        capture_check(8);

        // Reset in the middle of the payload, then a fresh frame.
        push_pkt(100, 1);
        n = 0;
        while (!bf_in_r_en && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_val("midrst_reach", 32'(n < 200), 32'd1);
        repeat (20) @(negedge clk);
        rst = 1'b1;
        flush = 1'b1;
        #1;
        check_val("midrst_txen", 32'(gmii_tx_en), 32'd0);
        check_val("midrst_txd", 32'(gmii_txd), 32'd0);
        check_val("midrst_ren", 32'(bf_in_r_en), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        flush = 1'b0;
        push_pkt(20, 1);
        capture_check(10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
